pong_serial_tx: RTL and testbench

Framed serial transmitter for the board-to-board link. It carries paddle and ball state words from the local FPGA to the remote FPGA. It accepts one parallel word per valid/ready handshake and shifts it out on a single wire: start bit, data LSB-first, optional even parity, then stop bit. It sits between the game-state logic, which is clocked by the 50 MHz clock, and the GPIO pin.

---
 rtl/pong_link_pkg.sv | 20 ++
 rtl/baud_tick_gen.sv | 37 +++
 rtl/pong_serial_tx.sv | 105 ++++++++++
 tb/tb_pong_serial_tx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_link_pkg.sv
// Shared types and constants for the board-to-board pong serial link.
package pong_link_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int unsigned LINK_CLKS_PER_BIT = 434;
   localparam int unsigned LINK_DATA_WIDTH   = 8;

   // Line bits per frame: start + data + optional parity + stop.
   function automatic int unsigned frame_bits(input int unsigned width, input bit parity);
      return 32'(2 + width + 32'(parity));
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: registered tick on the last clock of each bit period.
module baud_tick_gen #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count 0..CLKS_PER_BIT-1, held at zero while cleared.
   always_comb begin
      cnt_d = cnt_q;
      if (clr || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Tick is registered from the next count so it lines up with cnt_q == last.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         tick  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tick  <= (cnt_d == CNT_LAST);
      end
   end

endmodule

// File: rtl/pong_serial_tx.sv
// Framed serial transmitter: start, LSB-first data, optional even parity, stop.
module pong_serial_tx
   import pong_link_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = LINK_CLKS_PER_BIT,
   parameter int unsigned DATA_WIDTH   = LINK_DATA_WIDTH,
   parameter bit          PARITY_EN    = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  send,
   output logic                  ready,
   output logic                  tx_serial,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   tx_state_t             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic                  parity_q, parity_d;
   logic                  tx_d, done_d;
   logic                  tick, baud_clr, accept, last_bit;

   assign baud_clr = (state_q == IDLE);
   assign accept   = send && (state_q == IDLE);
   assign last_bit = (bit_q == BIT_LAST);

   baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .reset (reset),
      .clr   (baud_clr),
      .tick  (tick)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: every non-idle state lasts one bit period.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = START;
         START:   if (tick) state_d = DATA;
         DATA:    if (tick && last_bit) state_d = PARITY_EN ? PARITY : STOP;
         PARITY:  if (tick) state_d = STOP;
         STOP:    if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and line value, computed against the state being entered.
   always_comb begin
      shift_d  = shift_q;
      bit_d    = bit_q;
      parity_d = parity_q;
      done_d   = (state_q == STOP) && tick;
      if (accept) begin
         shift_d  = data_in;
         parity_d = ^data_in;
         bit_d    = '0;
      end else if ((state_q == DATA) && tick) begin
         shift_d = shift_q >> 1;
         bit_d   = last_bit ? '0 : bit_q + BIT_W'(1);
      end
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = parity_q;
         default: tx_d = 1'b1;
      endcase
   end

   // Registered datapath and outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q   <= '0;
         bit_q     <= '0;
         parity_q  <= 1'b0;
         tx_serial <= 1'b1;
         done      <= 1'b0;
         ready     <= 1'b1;
         busy      <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         bit_q     <= bit_d;
         parity_q  <= parity_d;
         tx_serial <= tx_d;
         done      <= done_d;
         ready     <= (state_d == IDLE);
         busy      <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_pong_serial_tx.sv
// Scoreboard bench: two transmitters (with and without parity) checked cycle by cycle.
module tb_pong_serial_tx;

   localparam int C  = 4;
   localparam int DW = 8;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] din [2];
   logic       snd [2];
   logic       rdy [2];
   logic       tx  [2];
   logic       bsy [2];
   logic       dn  [2];

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;

   // scoreboard state per DUT
   logic [7:0] fw [2][8];
   int wp [2], rp [2], cnt [2];
   int phase [2], mcyc [2];
   logic [7:0] cur_w [2];

   int to_req = 0, to_seen = 0;
   bit final_req = 1'b0, final_done = 1'b0;

   always #5 clk = ~clk;

   pong_serial_tx #(.CLKS_PER_BIT(C), .DATA_WIDTH(DW), .PARITY_EN(1'b1)) dut_p (
      .clk(clk), .reset(reset), .data_in(din[0]), .send(snd[0]),
      .ready(rdy[0]), .tx_serial(tx[0]), .busy(bsy[0]), .done(dn[0]));

   pong_serial_tx #(.CLKS_PER_BIT(C), .DATA_WIDTH(DW), .PARITY_EN(1'b0)) dut_n (
      .clk(clk), .reset(reset), .data_in(din[1]), .send(snd[1]),
      .ready(rdy[1]), .tx_serial(tx[1]), .busy(bsy[1]), .done(dn[1]));

   // Reference: bit k of the frame for word w.
   function automatic logic exp_bit(input logic [7:0] w, input int k, input int pen);
      if (k == 0) return 1'b0;
      if (k <= DW) return w[k-1];
      if (pen != 0 && k == DW + 1) return logic'($countones(w) % 2);
      return 1'b1;
   endfunction

   task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", nm, g, ncyc, act, exp);
      end
   endtask

   task automatic mon_step(input int g);
      int pen;
      int len;
      pen = (g == 0) ? 1 : 0;
      len = 2 + DW + pen;
      if (reset) begin
         chk("rst_tx", g, 32'(tx[g]), 1);
         chk("rst_ready", g, 32'(rdy[g]), 1);
         chk("rst_busy", g, 32'(bsy[g]), 0);
         chk("rst_done", g, 32'(dn[g]), 0);
         phase[g] = 0; cnt[g] = 0; rp[g] = 0; wp[g] = 0;
         return;
      end
      if (phase[g] == 0 && cnt[g] > 0) begin
         cur_w[g] = fw[g][rp[g]];
         rp[g] = (rp[g] + 1) % 8;
         cnt[g]--;
         phase[g] = 1;
         mcyc[g] = 0;
      end else if (phase[g] == 0) begin
         chk("idle_tx", g, 32'(tx[g]), 1);
         chk("idle_ready", g, 32'(rdy[g]), 1);
         chk("idle_busy", g, 32'(bsy[g]), 0);
         chk("idle_done", g, 32'(dn[g]), 0);
      end else if (phase[g] == 2) begin
         chk("done_pulse", g, 32'(dn[g]), 1);
         chk("done_ready", g, 32'(rdy[g]), 1);
         chk("done_tx", g, 32'(tx[g]), 1);
         phase[g] = 0;
      end
      if (phase[g] == 1) begin
         chk("line_bit", g, 32'(tx[g]), 32'(exp_bit(cur_w[g], mcyc[g] / C, pen)));
         chk("frame_ready", g, 32'(rdy[g]), 0);
         chk("frame_busy", g, 32'(bsy[g]), 1);
         chk("frame_done", g, 32'(dn[g]), 0);
         mcyc[g]++;
         if (mcyc[g] == len * C) phase[g] = 2;
      end
      // acceptance happens at the coming posedge
      if (snd[g] && rdy[g]) begin
         fw[g][wp[g]] = din[g];
         wp[g] = (wp[g] + 1) % 8;
         cnt[g]++;
      end
   endtask

   // Monitor: all comparisons happen here, away from the active edge.
   always @(negedge clk) begin
      ncyc++;
      for (int g = 0; g < 2; g++) mon_step(g);
      if (to_req != to_seen) begin
         checks++;
         errors++;
         $display("FAIL wait_timeout cycle %0d: got %0d timeouts, expected 0", ncyc, to_req - to_seen);
         to_seen = to_req;
      end
      if (final_req && !final_done) begin
         for (int g = 0; g < 2; g++) begin
            chk("fifo_drained", g, 32'(cnt[g]), 0);
            chk("monitor_idle", g, 32'(phase[g]), 0);
         end
         final_done = 1'b1;
      end
   end

   // Called at posedge+1; returns at posedge+1 right after acceptance.
   task automatic send_word(input int g, input logic [7:0] w, input bit hold);
      int n;
      din[g] = w;
      snd[g] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy[g] && n < 300);
      if (!rdy[g]) to_req++;
      @(posedge clk);
      #1;
      if (!hold) snd[g] = 1'b0;
   endtask

   task automatic wait_idle(input int g);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(phase[g] == 0 && cnt[g] == 0 && rdy[g]) && n < 300);
      if (n >= 300) to_req++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] w;
      bit hold;
      for (int g = 0; g < 2; g++) begin
         din[g] = '0; snd[g] = 1'b0;
         wp[g] = 0; rp[g] = 0; cnt[g] = 0; phase[g] = 0; mcyc[g] = 0; cur_w[g] = '0;
      end
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (50) @(posedge clk);
      #1;

      send_word(0, 8'hA5, 1'b0); wait_idle(0);
      send_word(0, 8'h07, 1'b0); wait_idle(0);
      send_word(1, 8'h07, 1'b0); wait_idle(1);

      send_word(0, 8'h00, 1'b1);
      send_word(0, 8'hFF, 1'b0);
      wait_idle(0);

      send_word(0, 8'h3C, 1'b0);
      repeat (9) @(posedge clk);
      #1 din[0] = 8'hC3; snd[0] = 1'b1;
      @(posedge clk);
      #1 snd[0] = 1'b0;
      wait_idle(0);

      send_word(0, 8'hB3, 1'b0);
      repeat (13) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      send_word(0, 8'h5A, 1'b0); wait_idle(0);

      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 12; i++) begin
            w = 8'($urandom);
            hold = ($urandom_range(0, 2) == 0);
            send_word(g, w, hold);
            if (!hold) repeat ($urandom_range(0, 5)) @(posedge clk);
         end
         snd[g] = 1'b0;
         wait_idle(g);
      end

      final_req = 1'b1;
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
